// File: rtl/systolic_out_deskew_acc.sv
// systolic_out_deskew_acc
// Removes the row skew of the systolic array output (row m lags row 0 by m
// cycles), accumulates the aligned vectors over a configurable number of
// reduction tiles and presents the finished vector on a valid/ready port.
//
// Handshake (out_valid/out_ready): a transfer happens on a rising clock edge
// where out_valid && out_ready. out_valid never drops without a transfer, and
// out_data is held stable while out_valid && !out_ready. There is no
// backpressure toward the array: a completion that finds the output register
// still occupied and not being drained is dropped and flagged on err_ovf.
//
// The FSM state is visible on busy (high exactly while in ACCUM).

module systolic_out_deskew_acc #(
  parameter int ARRAY_M      = 32,
  parameter int PE_OUT_WIDTH = 21,
  parameter int ACC_WIDTH    = 32,
  parameter int TILE_W       = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [ARRAY_M*PE_OUT_WIDTH-1:0] sys_out,
  input  logic [TILE_W-1:0]               cfg_tiles,
  output logic [ARRAY_M*ACC_WIDTH-1:0]    out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            err_ovf,
  input  logic                            err_clr
);

  // Number of register stages on the valid path; lane m needs DLY-m stages.
  localparam int DLY = ARRAY_M - 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Deskew
  // ---------------------------------------------------------------------------
  logic [DLY-1:0] vdly_q, vdly_d;
  logic           av;

  // Valid delay line: in_valid shifted DLY cycles to line up with the last row.
  always_comb begin
    vdly_d[0] = in_valid;
    for (int k = 1; k < DLY; k++) begin
      vdly_d[k] = vdly_q[k-1];
    end
  end

  // Valid delay line register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vdly_q <= '0;
    end else begin
      vdly_q <= vdly_d;
    end
  end

  assign av = vdly_q[DLY-1];

  // Aligned lane values, one per array row.
  logic signed [PE_OUT_WIDTH-1:0] lane_al [ARRAY_M];

  for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
    localparam int D = DLY - m;
    if (D == 0) begin : g_pass
      // The last row already arrives aligned with the delayed valid.
      assign lane_al[m] = sys_out[m*PE_OUT_WIDTH +: PE_OUT_WIDTH];
    end else begin : g_dly
      logic [PE_OUT_WIDTH-1:0] sh_q [D];
      logic [PE_OUT_WIDTH-1:0] sh_d [D];

      // Shift chain of D stages for this lane.
      always_comb begin
        sh_d[0] = sys_out[m*PE_OUT_WIDTH +: PE_OUT_WIDTH];
        for (int k = 1; k < D; k++) begin
          sh_d[k] = sh_q[k-1];
        end
      end

      // Shift chain register for this lane.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) begin
            sh_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < D; k++) begin
            sh_q[k] <= sh_d[k];
          end
        end
      end

      assign lane_al[m] = sh_q[D-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Tile-count FSM
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [TILE_W-1:0]  tiles_q, tiles_d;
  logic [TILE_W-1:0]  cnt_q, cnt_d;
  logic [TILE_W-1:0]  t_eff;
  logic               accum_last;
  logic               start_beat;
  logic               accum_beat;
  logic               complete;

  // A zero tile count is treated as a single-tile result.
  assign t_eff = (cfg_tiles == '0) ? TILE_W'(1) : cfg_tiles;

  // The beat being accumulated in ACCUM is the last one when it brings the
  // count up to the latched tile total.
  assign accum_last = (({1'b0, cnt_q} + (TILE_W+1)'(1)) == {1'b0, tiles_q});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the FSM only moves on an aligned beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (av && (t_eff != TILE_W'(1))) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (av && accum_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: beat qualifiers, completion strobe and busy.
  always_comb begin
    start_beat = 1'b0;
    accum_beat = 1'b0;
    complete   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_beat = av;
        complete   = av && (t_eff == TILE_W'(1));
      end
      S_ACCUM: begin
        busy       = 1'b1;
        accum_beat = av;
        complete   = av && accum_last;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulators and tile bookkeeping
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] acc_q [ARRAY_M];
  logic [ACC_WIDTH-1:0] acc_d [ARRAY_M];
  logic [ACC_WIDTH-1:0] sum   [ARRAY_M];

  // Sum of the current beat with the running total; a first beat starts from
  // zero so stale totals from the previous result never leak in.
  always_comb begin
    for (int m = 0; m < ARRAY_M; m++) begin
      sum[m]   = (start_beat ? '0 : acc_q[m]) + ACC_WIDTH'(lane_al[m]);
      acc_d[m] = av ? sum[m] : acc_q[m];
    end
  end

  // Tile total latched on the first beat; beat counter.
  always_comb begin
    tiles_d = tiles_q;
    cnt_d   = cnt_q;
    if (start_beat) begin
      tiles_d = t_eff;
      cnt_d   = TILE_W'(1);
    end else if (accum_beat) begin
      cnt_d   = cnt_q + TILE_W'(1);
    end
  end

  // Accumulator and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < ARRAY_M; m++) begin
        acc_q[m] <= '0;
      end
      tiles_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int m = 0; m < ARRAY_M; m++) begin
        acc_q[m] <= acc_d[m];
      end
      tiles_q <= tiles_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and overflow flag
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] out_data_q [ARRAY_M];
  logic [ACC_WIDTH-1:0] out_data_d [ARRAY_M];
  logic                 out_valid_q, out_valid_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 out_blocked;
  logic                 load;
  logic                 drop;

  // The register is blocked when it holds a result the consumer is refusing.
  assign out_blocked = out_valid_q && !out_ready;
  assign load        = complete && !out_blocked;
  assign drop        = complete && out_blocked;

  // Output register next state: reload on completion, clear on transfer.
  always_comb begin
    out_valid_d = out_valid_q;
    for (int m = 0; m < ARRAY_M; m++) begin
      out_data_d[m] = out_data_q[m];
    end
    if (load) begin
      out_valid_d = 1'b1;
      for (int m = 0; m < ARRAY_M; m++) begin
        out_data_d[m] = sum[m];
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Sticky overflow flag; a new drop outranks a same-cycle clear.
  always_comb begin
    err_ovf_d = err_ovf_q;
    if (drop) begin
      err_ovf_d = 1'b1;
    end else if (err_clr) begin
      err_ovf_d = 1'b0;
    end
  end

  // Output and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < ARRAY_M; m++) begin
        out_data_q[m] <= '0;
      end
      out_valid_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      for (int m = 0; m < ARRAY_M; m++) begin
        out_data_q[m] <= out_data_d[m];
      end
      out_valid_q <= out_valid_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  for (genvar m = 0; m < ARRAY_M; m++) begin : g_out
    assign out_data[m*ACC_WIDTH +: ACC_WIDTH] = out_data_q[m];
  end

  assign out_valid = out_valid_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_systolic_out_deskew_acc.sv
// Bench for systolic_out_deskew_acc (ARRAY_M=4, PE_OUT_WIDTH=12, ACC_WIDTH=16).
// The whole directed schedule is built up front; a beat-level model turns each
// result into a due cycle and an expected vector, and an output-register model
// applies the handshake rules cycle by cycle.

module tb_systolic_out_deskew_acc;

  localparam int M    = 4;
  localparam int PW   = 12;
  localparam int AW   = 16;
  localparam int TW   = 8;
  localparam int MAXC = 128;
  localparam int ENDC = 100;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [M*PW-1:0] sys_out = '0;
  logic [TW-1:0]   cfg_tiles = '0;
  logic [M*AW-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy;
  logic            err_ovf;
  logic            err_clr = 1'b0;

  always #5 clk = ~clk;

  systolic_out_deskew_acc #(
    .ARRAY_M(M), .PE_OUT_WIDTH(PW), .ACC_WIDTH(AW), .TILE_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sys_out(sys_out),
    .cfg_tiles(cfg_tiles), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .err_ovf(err_ovf), .err_clr(err_clr)
  );

  // ---------------------------------------------------------------------------
  // Per-cycle stimulus schedule and expectations derived from it
  // ---------------------------------------------------------------------------
  logic [PW-1:0]  lane_sched  [MAXC][M];
  logic           valid_sched [MAXC];
  logic [TW-1:0]  cfg_sched   [MAXC];
  logic           ready_sched [MAXC];
  logic           clr_sched   [MAXC];
  logic           rst_sched   [MAXC];
  logic           busy_sched  [MAXC];
  logic           comp_valid  [MAXC];
  logic [M*AW-1:0] comp_data  [MAXC];

  typedef struct {
    int          cyc;
    int          kind;   // 0 out_data, 1 busy, 2 err_ovf, 3 out_valid
    string       name;
    logic [63:0] val;
  } lit_t;
  lit_t lits[$];

  int total = 0;
  int bad   = 0;

  // Beat-level model of the result being assembled.
  bit bm_active = 0;
  int bm_t      = 0;
  int bm_cnt    = 0;
  int bm_sum [M];

  task automatic check(input string name, input int cyc, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic mark_busy(input int from, input logic val);
    for (int k = from; k < MAXC; k++) busy_sched[k] = val;
  endtask

  task automatic add_lit(input int cyc, input int kind, input string name,
                         input logic [63:0] val);
    lit_t l;
    l.cyc = cyc; l.kind = kind; l.name = name; l.val = val;
    lits.push_back(l);
  endtask

  // One beat: in_valid at cycle t, lane m presented at t+m. cfg only matters
  // for the first beat of a result and is held across its whole skew window.
  task automatic add_beat(input int t, input int v0, input int v1, input int v2,
                          input int v3, input int cfg);
    int v [M];
    logic [M*AW-1:0] pk;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    valid_sched[t] = 1'b1;
    for (int m = 0; m < M; m++) lane_sched[t+m][m] = PW'(v[m]);
    if (!bm_active) begin
      bm_active = 1;
      bm_t      = (cfg == 0) ? 1 : cfg;
      bm_cnt    = 0;
      for (int m = 0; m < M; m++) bm_sum[m] = 0;
      for (int k = t; k < t + M; k++) cfg_sched[k] = TW'(cfg);
    end
    for (int m = 0; m < M; m++) bm_sum[m] += v[m];
    bm_cnt++;
    if (bm_cnt == bm_t) begin
      for (int m = 0; m < M; m++) pk[m*AW +: AW] = AW'(bm_sum[m]);
      comp_valid[t+M] = 1'b1;
      comp_data[t+M]  = pk;
      bm_active = 0;
      mark_busy(t + M, 1'b0);
    end else begin
      mark_busy(t + M, 1'b1);
    end
  endtask

  // Output-register model state.
  logic            exp_valid = 1'b0;
  logic [M*AW-1:0] exp_data  = '0;
  logic            exp_err   = 1'b0;

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      for (int m = 0; m < M; m++) lane_sched[c][m] = '0;
      valid_sched[c] = 1'b0; cfg_sched[c] = '0; ready_sched[c] = 1'b1;
      clr_sched[c] = 1'b0; rst_sched[c] = 1'b0; busy_sched[c] = 1'b0;
      comp_valid[c] = 1'b0; comp_data[c] = '0;
    end
    rst_sched[0] = 1'b1;
    rst_sched[1] = 1'b1;
    add_lit(1, 0, "reset_data", 64'h0);

    // 1: single tile, lanes 1..4.
    add_beat(4, 1, 2, 3, 4, 1);
    add_lit(8, 0, "t1_data", 64'h0004_0003_0002_0001);
    add_lit(9, 3, "t1_valid_drop", 64'h0);

    // 2: three back-to-back tiles of -5.
    for (int i = 0; i < 3; i++) add_beat(12 + i, -5, -5, -5, -5, 3);
    add_lit(15, 1, "t2_busy_first", 64'h0);
    add_lit(17, 1, "t2_busy_mid", 64'h1);
    add_lit(18, 0, "t2_data", 64'hFFF1_FFF1_FFF1_FFF1);
    add_lit(18, 1, "t2_busy_done", 64'h0);

    // 3: seventeen tiles of 2047 wrap past 2^15.
    for (int i = 0; i < 17; i++) add_beat(22 + i, 2047, 2047, 2047, 2047, 17);
    add_lit(42, 0, "t3_wrap", 64'h87EF_87EF_87EF_87EF);

    // 4: two single-tile results against a stalled consumer.
    for (int c = 46; c <= 55; c++) ready_sched[c] = 1'b0;
    add_beat(46, 10, 20, 30, 40, 1);
    add_beat(47, 50, 60, 70, 80, 1);
    clr_sched[53] = 1'b1;
    add_lit(52, 0, "t4_held", 64'h0028_001E_0014_000A);
    add_lit(52, 2, "t4_err_set", 64'h1);
    add_lit(54, 2, "t4_err_clr", 64'h0);
    add_lit(56, 3, "t4_still_valid", 64'h1);
    add_lit(57, 3, "t4_drained", 64'h0);

    // 5: reset in the middle of a two-tile result, then a fresh result of 7s.
    add_beat(60, 100, 100, 100, 100, 2);
    bm_active = 0;
    rst_sched[65] = 1'b1;
    mark_busy(66, 1'b0);
    add_lit(65, 1, "t5_busy_pre_rst", 64'h1);
    add_beat(70, 7, 7, 7, 7, 1);
    add_lit(74, 0, "t5_fresh", 64'h0007_0007_0007_0007);

    // 6: cfg_tiles=0 acts as 1; cfg change during ACCUM is ignored.
    add_beat(78, -1, 2, -3, 4, 0);
    add_lit(82, 0, "t6_cfg0", 64'h0004_FFFD_0002_FFFF);
    for (int i = 0; i < 3; i++) add_beat(84 + i, 1, 2, 3, 4, 3);
    for (int c = 88; c < 96; c++) cfg_sched[c] = TW'(1);
    add_lit(89, 3, "t6_no_early", 64'h0);
    add_lit(90, 0, "t6_three_tiles", 64'h000C_0009_0006_0003);

    // Compare process: on each falling edge update the model, compare, then
    // drive the inputs for this cycle.
    for (int c = 0; c < ENDC; c++) begin
      @(negedge clk);
      if (c > 0 && !rst_sched[c-1]) begin
        if (comp_valid[c]) begin
          if (exp_valid && !ready_sched[c-1]) begin
            exp_err = 1'b1;
          end else begin
            exp_valid = 1'b1;
            exp_data  = comp_data[c];
            if (clr_sched[c-1]) exp_err = 1'b0;
          end
        end else begin
          if (exp_valid && ready_sched[c-1]) exp_valid = 1'b0;
          if (clr_sched[c-1]) exp_err = 1'b0;
        end
      end

      check("out_valid", c, 64'(out_valid), 64'(exp_valid));
      check("busy", c, 64'(busy), 64'(busy_sched[c]));
      check("err_ovf", c, 64'(err_ovf), 64'(exp_err));
      if (exp_valid) check("out_data", c, 64'(out_data), 64'(exp_data));

      foreach (lits[i]) begin
        if (lits[i].cyc == c) begin
          case (lits[i].kind)
            0:       check(lits[i].name, c, 64'(out_data), lits[i].val);
            1:       check(lits[i].name, c, 64'(busy), lits[i].val);
            2:       check(lits[i].name, c, 64'(err_ovf), lits[i].val);
            default: check(lits[i].name, c, 64'(out_valid), lits[i].val);
          endcase
        end
      end

      if (rst_sched[c]) begin
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_err   = 1'b0;
      end

      rst_n     = !rst_sched[c];
      in_valid  = valid_sched[c];
      cfg_tiles = cfg_sched[c];
      out_ready = ready_sched[c];
      err_clr   = clr_sched[c];
      for (int m = 0; m < M; m++) sys_out[m*PW +: PW] = lane_sched[c][m];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
